logic_gate_unit: RTL
====================

Name: logic_gate_unit

Overview:
Parametrised, registered successor to the single-bit inverter. It applies one of eight bitwise gate operations to WIDTH-bit operands and returns the result through a 2-entry output buffer with valid/ready handshakes on both sides. Each result carries a parity bit, and the block keeps a wrapping count of accepted transactions. It sits between operand producers and result consumers that may stall.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of the transaction counter (>=1)

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_op  input  3  operation select, sampled with the beat
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored for NOT/BUF)
out_valid  output  1  head result valid
out_ready  input  1  consumer accepts head result
out_y  output  WIDTH  head result
out_parity  output  1  XOR-reduction of out_y
txn_count  output  CNT_W  accepted-beat count, wraps modulo 2^CNT_W

Behaviour:
- Op encoding: 000 y=~a; 001 a&b; 010 a|b; 011 a^b; 100 ~(a&b); 101 ~(a|b); 110 ~(a^b); 111 y=a (BUF).
- Accept (push) when in_valid & in_ready at a rising edge. Result and parity are computed from the in_op/in_a/in_b values sampled at that edge and written into the buffer.
- Pop when out_valid & out_ready at a rising edge.
- Buffer: 2-entry FIFO, occupancy cnt in {0,1,2}, output in order of acceptance.
- in_ready = rst_n & (cnt != 2). Purely occupancy-based: at cnt=2 a same-cycle pop does not raise in_ready.
- out_valid = (cnt != 0). out_y and out_parity are driven from the head entry and are registered, with no combinational path from in_* to out_*.
- Latency: a beat accepted at edge k appears on out_* after edge k, provided the buffer was empty. Back-to-back throughput is 1 beat/cycle when out_ready is held high.
- Push and pop in the same cycle: at cnt=1, cnt stays 1, the old head leaves and the new entry becomes head. At cnt=0 only a push is possible; at cnt=2 only a pop is possible.
- out_* hold their values while out_valid & ~out_ready (stall stability). The consumer may deassert out_ready at any time without loss.
- When cnt=0, out_y and out_parity hold their last value; the bench must not check them.
- txn_count increments by 1 on every push and wraps from 2^CNT_W-1 to 0.
- Reset (rst_n low, asynchronous, at any time including mid-transfer):
  - cnt=0; buffer contents, out_y, out_parity and txn_count go to 0.
  - out_valid=0 and in_ready=0 while rst_n=0.
  - A beat presented during reset is dropped.
  - in_ready rises immediately on deassertion; out_valid stays 0 until the first push.
- No X-propagation: in_op is fully decoded, so all 8 codes are legal.

Test Plan:
- Reset: rst_n=0 mid-stream with cnt=2 -> out_valid=0, in_ready=0, txn_count=0, out_y=0 immediately. After release, in_ready=1 and out_valid=0.
- All ops with WIDTH=8, a=8'hC5, b=8'h3A, out_ready=1:
  - NOT 3A/p0; AND 00/p0; OR FF/p0; XOR FF/p0
  - NAND FF/p0; NOR 00/p0; XNOR 00/p0; BUF C5/p0
  - Results appear in order, 1 cycle after each accept.
- Backpressure: out_ready=0, push a=01, 02, 03 with op BUF.
  - After two pushes, in_ready=0 and the third beat is held.
  - Raise out_ready: 01, 02, 03 emerge in order. While stalled, out_y stays 01 and parity=1.
- Simultaneous push/pop at cnt=1: streaming input with out_ready=1 for 10 cycles -> cnt stays 1, 10 results emerge in order, no bubbles.
- Counter wrap: CNT_W=4, push 17 beats -> txn_count reads 15 after beat 15, 0 after beat 16, 1 after beat 17.
- Width corner: WIDTH=1, a=1, op NOT -> out_y=0, out_parity=0. With a=0 -> out_y=1, parity=1.

Source files
------------

// File: rtl/logic_gate_unit.sv
// Registered bitwise gate unit: applies one of eight gate ops to WIDTH-bit operands and
// returns results with parity through a 2-entry valid/ready buffer, counting accepted beats.
module logic_gate_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_parity,
   output logic [CNT_W-1:0] txn_count
);

   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] head_y_q, head_y_d;
   logic [WIDTH-1:0] tail_y_q, tail_y_d;
   logic             head_p_q, head_p_d;
   logic             tail_p_q, tail_p_d;
   logic [CNT_W-1:0] txn_q, txn_d;
   logic [WIDTH-1:0] res_y;
   logic             res_p;
   logic             push, pop;

   always_comb begin
      res_y = '0;
      unique case (in_op)
         3'b000: res_y = ~in_a;
         3'b001: res_y = in_a & in_b;
         3'b010: res_y = in_a | in_b;
         3'b011: res_y = in_a ^ in_b;
         3'b100: res_y = ~(in_a & in_b);
         3'b101: res_y = ~(in_a | in_b);
         3'b110: res_y = ~(in_a ^ in_b);
         3'b111: res_y = in_a;
      endcase
      res_p = ^res_y;
   end

   // Ready depends only on occupancy, so a full buffer never accepts even while popping.
   assign in_ready  = rst_n & (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      cnt_d    = cnt_q;
      head_y_d = head_y_q;
      head_p_d = head_p_q;
      tail_y_d = tail_y_q;
      tail_p_d = tail_p_q;
      txn_d    = txn_q;
      if (push) begin
         txn_d = txn_q + CNT_W'(1);
      end
      unique case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_y_d = res_y;
               head_p_d = res_p;
            end else begin
               tail_y_d = res_y;
               tail_p_d = res_p;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            // Draining to empty keeps the old head visible on out_* (not valid).
            if (cnt_q == 2'd2) begin
               head_y_d = tail_y_q;
               head_p_d = tail_p_q;
            end
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            // Only reachable at one entry: new beat replaces the departing head.
            head_y_d = res_y;
            head_p_d = res_p;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         head_y_q <= '0;
         head_p_q <= 1'b0;
         tail_y_q <= '0;
         tail_p_q <= 1'b0;
         txn_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         head_y_q <= head_y_d;
         head_p_q <= head_p_d;
         tail_y_q <= tail_y_d;
         tail_p_q <= tail_p_d;
         txn_q    <= txn_d;
      end
   end

   assign out_y      = head_y_q;
   assign out_parity = head_p_q;
   assign txn_count  = txn_q;

endmodule
